// File: rtl/store_narrow_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_narrow_unit_pkg
// Description : Shared encodings for the store narrowing unit: store size
//               codes, byte-lane masks and issue-FSM state constants.
// Revision    : 1.0 - initial release
// ============================================================================
package store_narrow_unit_pkg;

    // Store size encoding as delivered by the execute stage
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Byte-lane masks before shifting to the address offset
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    // Issue FSM states
    localparam logic [0:0] ISSUE0 = 1'b0;
    localparam logic [0:0] ISSUE1 = 1'b1;

    // Unshifted byte-enable mask for a size code
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = MASK_BYTE;
            SZ_HALF: size_mask = MASK_HALF;
            SZ_WORD: size_mask = MASK_WORD;
            default: size_mask = MASK_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_lane_format.sv
`default_nettype none
// ============================================================================
// Module      : store_lane_format
// Description : Combinational store formatter. Narrows register data to the
//               requested size, shifts it onto the byte lanes selected by the
//               address offset and produces byte enables. With macro
//               STORE_SPLIT_EN defined, word-crossing stores produce a second
//               beat; otherwise misaligned half/word stores are flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module store_lane_format
    import store_narrow_unit_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr,
    input  logic [31:0]   data,
    input  logic [1:0]    size,
    output logic [AW-3:0] beat0_word,
    output logic [31:0]   beat0_data,
    output logic [3:0]    beat0_be,
`ifdef STORE_SPLIT_EN
    output logic [AW-3:0] beat1_word,
    output logic [31:0]   beat1_data,
    output logic [3:0]    beat1_be,
    output logic          two_beat,
`endif
    output logic          misaligned
);

    logic [1:0]  w_off;
    logic [3:0]  w_mask;
    logic [31:0] w_data_n;

    assign w_off      = addr[1:0];
    assign w_mask     = size_mask(size);
    assign beat0_word = addr[AW-1:2];

    // Keep only the bytes the store size actually writes
    always_comb begin
        case (size)
            SZ_BYTE: w_data_n = {24'b0, data[7:0]};
            SZ_HALF: w_data_n = {16'b0, data[15:0]};
            SZ_WORD: w_data_n = data;
            default: w_data_n = 32'b0;
        endcase
    end

`ifdef STORE_SPLIT_EN
    logic [63:0] w_shift;
    logic [7:0]  w_en;

    // Lanes that spill past byte 3 belong to the next word
    assign w_shift    = {32'b0, w_data_n} << {w_off, 3'b000};
    assign w_en       = {4'b0, w_mask} << w_off;
    assign beat0_data = w_shift[31:0];
    assign beat0_be   = w_en[3:0];
    assign beat1_data = w_shift[63:32];
    assign beat1_be   = w_en[7:4];
    assign two_beat   = |w_en[7:4];
    assign beat1_word = addr[AW-1:2] + {{(AW-3){1'b0}}, 1'b1};
    assign misaligned = (size == SZ_RSVD);
`else
    // Legal stores never leave the word, so truncating the shift is exact
    assign beat0_data = w_data_n << {w_off, 3'b000};
    assign beat0_be   = w_mask << w_off;
    assign misaligned = (size == SZ_RSVD)
                      || ((size == SZ_HALF) && addr[0])
                      || ((size == SZ_WORD) && (w_off != 2'b00));
`endif

endmodule
`default_nettype wire

// File: rtl/store_narrow_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_narrow_unit
// Description : Store narrowing unit with a small store buffer. Formats
//               execute-stage stores onto byte lanes, queues them and issues
//               word-aligned beats to the data-memory write port. Misaligned
//               stores are accepted, dropped and reported.
//               Optional macro STORE_SPLIT_EN: misaligned half/word stores
//               are split into one or two aligned beats.
// Revision    : 1.0 - initial release
// ============================================================================
module store_narrow_unit
    import store_narrow_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_data,
    input  logic [1:0]    req_size,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic          misalign,
    output logic [AW-1:0] misalign_addr,
    output logic          busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Formatter outputs
    logic [AW-3:0] w_b0_word;
    logic [31:0]   w_b0_data;
    logic [3:0]    w_b0_be;
    logic          w_misaligned;

    // Store buffer storage and control
    logic [AW-3:0] r_b0_word [DEPTH];
    logic [31:0]   r_b0_data [DEPTH];
    logic [3:0]    r_b0_be   [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_misalign;
    logic [AW-1:0] r_misalign_addr;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_beat_done;
    logic w_head_two;
    logic w_in_issue1;

`ifdef STORE_SPLIT_EN
    logic [AW-3:0] w_b1_word;
    logic [31:0]   w_b1_data;
    logic [3:0]    w_b1_be;
    logic          w_two_beat;
    logic [AW-3:0] r_b1_word [DEPTH];
    logic [31:0]   r_b1_data [DEPTH];
    logic [3:0]    r_b1_be   [DEPTH];
    logic          r_two_beat [DEPTH];
    logic [0:0]    r_state;
`endif

    store_lane_format #(
        .AW (AW)
    ) u_format (
        .addr       (req_addr),
        .data       (req_data),
        .size       (req_size),
        .beat0_word (w_b0_word),
        .beat0_data (w_b0_data),
        .beat0_be   (w_b0_be),
`ifdef STORE_SPLIT_EN
        .beat1_word (w_b1_word),
        .beat1_data (w_b1_data),
        .beat1_be   (w_b1_be),
        .two_beat   (w_two_beat),
`endif
        .misaligned (w_misaligned)
    );

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign req_ready   = !w_full;
    assign w_accept    = req_valid && req_ready;
    assign w_push      = w_accept && !w_misaligned;
    assign mem_valid   = !w_empty;
    assign w_beat_done = mem_valid && mem_ready;
    // An entry leaves the buffer only after its last beat is taken
    assign w_pop       = w_beat_done && (w_in_issue1 || !w_head_two);
    assign busy        = (r_count != '0) || mem_valid;
    assign misalign      = r_misalign;
    assign misalign_addr = r_misalign_addr;

`ifdef STORE_SPLIT_EN
    assign w_head_two  = r_two_beat[r_rd_ptr];
    assign w_in_issue1 = (r_state == ISSUE1);
`else
    assign w_head_two  = 1'b0;
    assign w_in_issue1 = 1'b0;
`endif

    // Buffer payload write at the tail; storage needs no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_b0_word[r_wr_ptr] <= w_b0_word;
            r_b0_data[r_wr_ptr] <= w_b0_data;
            r_b0_be[r_wr_ptr]   <= w_b0_be;
`ifdef STORE_SPLIT_EN
            r_b1_word[r_wr_ptr]  <= w_b1_word;
            r_b1_data[r_wr_ptr]  <= w_b1_data;
            r_b1_be[r_wr_ptr]    <= w_b1_be;
            r_two_beat[r_wr_ptr] <= w_two_beat;
`endif
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef STORE_SPLIT_EN
    // Issue FSM: second beat of a word-crossing store follows the first
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ISSUE0;
        end else begin
            case (r_state)
                ISSUE0:  if (w_beat_done && w_head_two) r_state <= ISSUE1;
                ISSUE1:  if (mem_ready) r_state <= ISSUE0;
                default: r_state <= ISSUE0;
            endcase
        end
    end
`endif

    // Present the current head beat; zero when idle so idle outputs are clean
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (mem_valid) begin
`ifdef STORE_SPLIT_EN
            if (w_in_issue1) begin
                mem_addr  = {r_b1_word[r_rd_ptr], 2'b00};
                mem_wdata = r_b1_data[r_rd_ptr];
                mem_be    = r_b1_be[r_rd_ptr];
            end else
`endif
            begin
                mem_addr  = {r_b0_word[r_rd_ptr], 2'b00};
                mem_wdata = r_b0_data[r_rd_ptr];
                mem_be    = r_b0_be[r_rd_ptr];
            end
        end
    end

    // One-cycle error pulse and capture of the rejected address
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign <= w_accept && w_misaligned;
            if (w_accept && w_misaligned) begin
                r_misalign_addr <= req_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_narrow_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_narrow_unit
// Description : Directed self-checking bench for store_narrow_unit.
//               Inputs change and outputs are observed on the falling edge.
//               Macro STORE_SPLIT_EN selects the split-store scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    store_narrow_unit #(
        .DEPTH (2),
        .AW    (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_size      (req_size),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .misalign      (misalign),
        .misalign_addr (misalign_addr),
        .busy          (busy)
    );

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({mem_valid, mem_be, busy, misalign} !== 7'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {mem_valid, mem_be, busy, misalign}); end
        checks++; if ({mem_addr, mem_wdata, misalign_addr} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, misalign_addr}); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_byte_store();
        @(negedge clk);
        mem_ready = 1'b1;
        drive(1'b1, 32'h1003, 32'h0000_00AB, 2'b00);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL sb_valid: got %b expected 1", mem_valid); end
        checks++; if (mem_addr !== 32'h1000) begin errors++; $display("FAIL sb_addr: got %h expected 00001000", mem_addr); end
        checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", mem_be); end
        checks++; if (mem_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL sb_wdata: got %h expected ab000000", mem_wdata); end
        @(negedge clk);
        checks++; if ({mem_valid, busy} !== 2'b00) begin errors++; $display("FAIL sb_single_beat: got %b expected 00", {mem_valid, busy}); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        mem_ready = 1'b1;
        drive(1'b1, 32'h2002, 32'hFFFF_1234, 2'b01);
        @(negedge clk);
        checks++; if ({mem_valid, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h2000, 4'b1100, 32'h1234_0000}) begin errors++; $display("FAIL sh_beat: got %b %h %b %h expected 1 00002000 1100 12340000", mem_valid, mem_addr, mem_be, mem_wdata); end
        drive(1'b1, 32'h2004, 32'hDEAD_BEEF, 2'b10);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        checks++; if ({mem_valid, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h2004, 4'b1111, 32'hDEAD_BEEF}) begin errors++; $display("FAIL sw_beat: got %b %h %b %h expected 1 00002004 1111 deadbeef", mem_valid, mem_addr, mem_be, mem_wdata); end
        @(negedge clk);
        checks++; if ({mem_valid, busy} !== 2'b00) begin errors++; $display("FAIL b2b_drain: got %b expected 00", {mem_valid, busy}); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        mem_ready = 1'b0;
        drive(1'b1, 32'h4000, 32'h0000_0011, 2'b00);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b expected 1", req_ready); end
        drive(1'b1, 32'h4001, 32'h0000_0022, 2'b00);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", req_ready); end
        drive(1'b1, 32'h4002, 32'h0000_0033, 2'b00);
        @(negedge clk);
        checks++; if ({req_ready, mem_addr, mem_be, mem_wdata} !== {1'b0, 32'h4000, 4'b0001, 32'h0000_0011}) begin errors++; $display("FAIL bp_stable: got %b %h %b %h expected 0 00004000 0001 00000011", req_ready, mem_addr, mem_be, mem_wdata); end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if ({req_ready, mem_be, mem_wdata} !== {1'b1, 4'b0010, 32'h0000_2200}) begin errors++; $display("FAIL bp_second: got %b %b %h expected 1 0010 00002200", req_ready, mem_be, mem_wdata); end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        checks++; if ({mem_addr, mem_be, mem_wdata} !== {32'h4000, 4'b0100, 32'h0033_0000}) begin errors++; $display("FAIL bp_third: got %h %b %h expected 00004000 0100 00330000", mem_addr, mem_be, mem_wdata); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", busy); end
        @(negedge clk);
        checks++; if ({mem_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_idle: got %b expected 00", {mem_valid, busy}); end
    endtask

    task automatic test_misalign();
        @(negedge clk);
        mem_ready = 1'b1;
`ifndef STORE_SPLIT_EN
        drive(1'b1, 32'h3001, 32'h1122_3344, 2'b10);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mis_ready: got %b expected 1", req_ready); end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        checks++; if ({misalign, mem_valid, busy} !== 3'b100) begin errors++; $display("FAIL mis_sw_pulse: got %b expected 100", {misalign, mem_valid, busy}); end
        checks++; if (misalign_addr !== 32'h3001) begin errors++; $display("FAIL mis_sw_addr: got %h expected 00003001", misalign_addr); end
        @(negedge clk);
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b expected 0", misalign); end
        drive(1'b1, 32'h2001, 32'h0000_5566, 2'b01);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        checks++; if ({misalign, mem_valid, misalign_addr} !== {2'b10, 32'h2001}) begin errors++; $display("FAIL mis_sh: got %b %b %h expected 1 0 00002001", misalign, mem_valid, misalign_addr); end
        @(negedge clk);
`endif
        drive(1'b1, 32'h3008, 32'h0000_0077, 2'b11);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        checks++; if ({misalign, mem_valid, misalign_addr} !== {2'b10, 32'h3008}) begin errors++; $display("FAIL mis_rsvd: got %b %b %h expected 1 0 00003008", misalign, mem_valid, misalign_addr); end
        @(negedge clk);
        checks++; if ({misalign, busy} !== 2'b00) begin errors++; $display("FAIL mis_rsvd_clear: got %b expected 00", {misalign, busy}); end
    endtask

`ifdef STORE_SPLIT_EN
    task automatic test_split();
        @(negedge clk);
        mem_ready = 1'b1;
        drive(1'b1, 32'h3003, 32'h1122_3344, 2'b10);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        checks++; if ({mem_valid, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h3000, 4'b1000, 32'h4400_0000}) begin errors++; $display("FAIL split_beat0: got %b %h %b %h expected 1 00003000 1000 44000000", mem_valid, mem_addr, mem_be, mem_wdata); end
        @(negedge clk);
        checks++; if ({mem_valid, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h3004, 4'b0111, 32'h0011_2233}) begin errors++; $display("FAIL split_beat1: got %b %h %b %h expected 1 00003004 0111 00112233", mem_valid, mem_addr, mem_be, mem_wdata); end
        drive(1'b1, 32'h5001, 32'h0000_ABCD, 2'b01);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        checks++; if ({misalign, mem_addr, mem_be, mem_wdata} !== {1'b0, 32'h5000, 4'b0110, 32'h00AB_CD00}) begin errors++; $display("FAIL split_half_in_word: got %b %h %b %h expected 0 00005000 0110 00abcd00", misalign, mem_addr, mem_be, mem_wdata); end
        @(negedge clk);
        checks++; if ({mem_valid, busy} !== 2'b00) begin errors++; $display("FAIL split_drain: got %b expected 00", {mem_valid, busy}); end
    endtask
`endif

    task automatic test_reset_mid();
        @(negedge clk);
`ifdef STORE_SPLIT_EN
        mem_ready = 1'b1;
        drive(1'b1, 32'h3003, 32'h1122_3344, 2'b10);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        mem_ready = 1'b0;
        checks++; if ({mem_valid, mem_addr} !== {1'b1, 32'h3004}) begin errors++; $display("FAIL rst_mid_in_issue1: got %b %h expected 1 00003004", mem_valid, mem_addr); end
`else
        mem_ready = 1'b0;
        drive(1'b1, 32'h6000, 32'h0000_0001, 2'b10);
        @(negedge clk);
        drive(1'b1, 32'h6004, 32'h0000_0002, 2'b10);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        checks++; if ({mem_valid, req_ready} !== 2'b10) begin errors++; $display("FAIL rst_mid_full: got %b expected 10", {mem_valid, req_ready}); end
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({mem_valid, busy, req_ready} !== 3'b001) begin errors++; $display("FAIL rst_mid_flush: got %b expected 001", {mem_valid, busy, req_ready}); end
        checks++; if ({mem_addr, mem_be} !== 36'h0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 0", {mem_addr, mem_be}); end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stays_empty: got %b expected 0", mem_valid); end
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_back_to_back();
        test_backpressure();
        test_misalign();
`ifdef STORE_SPLIT_EN
        test_split();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
